// File: rtl/syscall_console.sv
// Console back end for committed MIPS syscalls: queues print-int, print-char and exit
// requests and streams the resulting ASCII bytes over a valid/ready interface.
module syscall_console #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_W      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syscall_valid,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        req_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic        bad_syscall,
    output logic        busy
);

    localparam logic [3:0]     CodePrintInt  = 4'd1;
    localparam logic [3:0]     CodeExit      = 4'd10;
    localparam logic [3:0]     CodePrintChar = 4'd11;
    localparam logic [PTR_W:0] DepthC        = FIFO_DEPTH[PTR_W:0];
    localparam int unsigned    NumDigits     = 10;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StConv,
        StSign,
        StDigits,
        StNl,
        StChar,
        StExit,
        StHalted
    } state_t;

    // Request FIFO
    logic [35:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             req_ready_q, req_ready_d;
    logic             exit_pending_q, exit_pending_d;
    logic             bad_q;
    logic             supported, accept, push, pop;
    logic [35:0]      head;

    // Conversion / emit state
    state_t      state_q;
    logic [31:0] arg_q;
    logic        neg_q;
    logic [31:0] mag_q;
    logic [3:0]  digit_q [NumDigits];
    logic [3:0]  ndig_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        halt_q;

    logic [31:0] quot;
    logic [3:0]  rem;
    logic [3:0]  top_digit;
    logic [7:0]  top_ascii;

    always_comb begin
        supported = (v0 == 32'd1) || (v0 == 32'd10) || (v0 == 32'd11);
        accept    = syscall_valid && req_ready_q;
        push      = accept && supported;
        pop       = (state_q == StIdle) && (count_q != '0);
        head      = fifo_mem[rd_ptr_q];

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        exit_pending_d = exit_pending_q || (push && (v0 == 32'd10));
        // Registered from the next count so a pop never opens a slot in the same cycle
        req_ready_d    = (count_d < DepthC) && !exit_pending_d && !halt_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {v0[3:0], a0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            req_ready_q    <= 1'b1;
            exit_pending_q <= 1'b0;
            bad_q          <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q        <= count_d;
            req_ready_q    <= req_ready_d;
            exit_pending_q <= exit_pending_d;
            bad_q          <= accept && !supported;
        end
    end

    always_comb begin
        quot      = mag_q / 32'd10;
        rem       = 4'(mag_q % 32'd10);
        top_digit = digit_q[ndig_q - 4'd1];
        top_ascii = {4'h3, top_digit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            arg_q      <= '0;
            neg_q      <= 1'b0;
            mag_q      <= '0;
            ndig_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            halt_q     <= 1'b0;
            for (int i = 0; i < NumDigits; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        arg_q <= head[31:0];
                        case (head[35:32])
                            CodePrintInt:  state_q <= StLoad;
                            CodePrintChar: state_q <= StChar;
                            CodeExit:      state_q <= StExit;
                            default:       state_q <= StIdle;
                        endcase
                    end
                end
                StLoad: begin
                    neg_q   <= arg_q[31];
                    mag_q   <= arg_q[31] ? (~arg_q + 32'd1) : arg_q;
                    ndig_q  <= '0;
                    state_q <= StConv;
                end
                StConv: begin
                    // Least significant digit lands at the bottom of the stack
                    digit_q[ndig_q] <= rem;
                    ndig_q          <= ndig_q + 4'd1;
                    mag_q           <= quot;
                    if (quot == '0) begin
                        state_q <= neg_q ? StSign : StDigits;
                    end
                end
                StSign: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= 8'h2D;
                    end else if (tx_ready) begin
                        tx_data_q <= top_ascii;
                        ndig_q    <= ndig_q - 4'd1;
                        state_q   <= StDigits;
                    end
                end
                StDigits: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= top_ascii;
                        ndig_q     <= ndig_q - 4'd1;
                    end else if (tx_ready) begin
                        if (ndig_q == '0) begin
                            tx_data_q <= 8'h0A;
                            state_q   <= StNl;
                        end else begin
                            tx_data_q <= top_ascii;
                            ndig_q    <= ndig_q - 4'd1;
                        end
                    end
                end
                StNl: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StChar: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= arg_q[7:0];
                    end else if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StExit: begin
                    halt_q  <= 1'b1;
                    state_q <= StHalted;
                end
                StHalted: begin
                    tx_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        req_ready   = req_ready_q;
        tx_valid    = tx_valid_q;
        tx_data     = tx_data_q;
        halt        = halt_q;
        bad_syscall = bad_q;
        busy        = !((state_q == StHalted) || ((state_q == StIdle) && (count_q == '0)));
    end

endmodule

// File: tb/tb_syscall_console.sv
// Directed bench for syscall_console: expected bytes go into a queue that a
// negedge monitor drains against every tx transfer.
module tb_syscall_console;

    logic        clk;
    logic        rst_n;
    logic        syscall_valid;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic        bad_syscall;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [7:0] exp_q[$];
    logic       stall_seen = 1'b0;
    logic [7:0] stall_data = 8'h00;

    syscall_console #(
        .FIFO_DEPTH(4),
        .PTR_W     (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .syscall_valid(syscall_valid),
        .v0           (v0),
        .a0           (a0),
        .req_ready    (req_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .halt         (halt),
        .bad_syscall  (bad_syscall),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: compares every transfer with the scoreboard and checks hold-while-stalled
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                checks++;
                if (!tx_valid || tx_data !== stall_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data=%02h, required valid=1 data=%02h",
                             tx_valid, tx_data, stall_data);
                end
            end
            if (tx_valid && tx_ready) begin
                xfers++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte: got unexpected %02h, required no transfer", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte: got %02h, required %02h", tx_data, e);
                    end
                end
            end
            stall_seen = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic exp_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Must be entered just after a rising edge; leaves just after the sampling edge
    task automatic sys(input logic [31:0] code, input logic [31:0] arg, output logic rdy);
        syscall_valid = 1'b1;
        v0            = code;
        a0            = arg;
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
        syscall_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy || tx_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, n >= 2000}, 32'd0);
    endtask

    task automatic reset_quick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic r;
        int   n;
        int   x0;
        logic exp_rdy [6];

        rst_n         = 1'b0;
        syscall_valid = 1'b0;
        v0            = '0;
        a0            = '0;
        tx_ready      = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset tx_data", {24'd0, tx_data}, 32'd0);
        check("reset halt", {31'd0, halt}, 32'd0);
        check("reset bad_syscall", {31'd0, bad_syscall}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);

        // Print 123: first byte 3+3 cycles after the pop cycle, then back-to-back
        exp_str("123\n");
        align();
        sys(32'd1, 32'd123, r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 50);
        check("latency 123", n, 32'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("back-to-back", {31'd0, tx_valid}, 32'd1);
        end
        drain("drain 123");
        check("idle busy", {31'd0, busy}, 32'd0);

        // Zero, most negative and minus one
        exp_str("0\n");
        exp_str("-2147483648\n");
        exp_str("-1\n");
        align();
        sys(32'd1, 32'd0, r);
        sys(32'd1, 32'h8000_0000, r);
        sys(32'd1, 32'hFFFF_FFFF, r);
        drain("drain edge ints");

        // Backpressure with tx_ready toggling every cycle
        x0 = xfers;
        exp_str("45\n");
        align();
        sys(32'd1, 32'd45, r);
        for (int i = 0; i < 40; i++) begin
            tx_ready = ~tx_ready;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        drain("drain 45");
        check("transfers 45", xfers - x0, 32'd3);

        // FIFO full: a stuck print occupies the FSM, then six back-to-back requests
        tx_ready = 1'b0;
        exp_str("1\n11\n22\n33\n44\n");
        align();
        sys(32'd1, 32'd1, r);
        repeat (10) @(posedge clk);
        #1;
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            sys(32'd1, 32'(11 * (i + 1)), r);
            check($sformatf("full req_ready %0d", i), {31'd0, r}, {31'd0, exp_rdy[i]});
        end
        tx_ready = 1'b1;
        drain("drain full");

        // Exit ordering
        exp_str("7\nA");
        align();
        sys(32'd1, 32'd7, r);
        sys(32'd11, 32'h41, r);
        sys(32'd10, 32'd0, r);
        sys(32'd1, 32'd9, r);
        check("post-exit req_ready", {31'd0, r}, 32'd0);
        n = 0;
        while (!halt && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("halt rises", {31'd0, halt}, 32'd1);
        check("halt after A", exp_q.size(), 32'd0);
        repeat (20) @(negedge clk);
        check("halt sticky", {31'd0, halt}, 32'd1);
        check("halted tx_valid", {31'd0, tx_valid}, 32'd0);
        check("halted busy", {31'd0, busy}, 32'd0);
        check("halted req_ready", {31'd0, req_ready}, 32'd0);

        // Unsupported code
        reset_quick();
        check("reset clears halt", {31'd0, halt}, 32'd0);
        align();
        sys(32'd5, 32'd3, r);
        @(negedge clk);
        check("bad pulse", {31'd0, bad_syscall}, 32'd1);
        check("bad no push", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("bad one cycle", {31'd0, bad_syscall}, 32'd0);
        check("bad no tx", {31'd0, tx_valid}, 32'd0);

        // Reset in the middle of a long number
        exp_str("-2147483648\n");
        align();
        sys(32'd1, 32'h8000_0000, r);
        n = 0;
        while (exp_q.size() > 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid-output reached", {31'd0, n >= 200}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async tx_valid", {31'd0, tx_valid}, 32'd0);
        check("async busy", {31'd0, busy}, 32'd0);
        check("async halt", {31'd0, halt}, 32'd0);
        check("async req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_str("1\n");
        align();
        sys(32'd1, 32'd1, r);
        drain("drain after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
